// File: rtl/ecap5_dproc_pkg.sv
// Shared constants and helpers for the decode-stage hazard controller.
// Holds forward-select encodings, parameter defaults and the saturating counter step.
package ecap5_dproc_pkg;

  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int NB_STAGES_DEF    = 3;
  localparam int FWD_EN_DEF       = 1;

  localparam logic [2:0] FWD_SEL_RF = 3'd0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority match of one decode operand against the downstream writer stages.
// The youngest matching stage decides between forwarding and stalling.
module hazard_match
  import ecap5_dproc_pkg::*;
#(
  parameter int NB_STAGES = NB_STAGES_DEF,
  parameter int FWD_EN    = FWD_EN_DEF
) (
  input  logic [4:0]             raddr_i,
  input  logic [NB_STAGES-1:0]   stg_reg_write_i,
  input  logic [5*NB_STAGES-1:0] stg_reg_addr_i,
  input  logic [NB_STAGES-1:0]   stg_result_valid_i,
  output logic [2:0]             fwd_sel_o,
  output logic                   stall_o
);

  logic       w_hit;
  logic       w_vld;
  logic [2:0] w_sel;

  always_comb begin
    w_hit = 1'b0;
    w_vld = 1'b0;
    w_sel = FWD_SEL_RF;
    // Walk oldest to youngest so the youngest match overwrites older ones.
    for (int i = NB_STAGES - 1; i >= 0; i--) begin
      if (stg_reg_write_i[i] && (raddr_i != 5'd0) &&
          (stg_reg_addr_i[5*i +: 5] == raddr_i)) begin
        w_hit = 1'b1;
        w_vld = stg_result_valid_i[i];
        w_sel = 3'(i + 1);
      end
    end
  end

  always_comb begin
    fwd_sel_o = FWD_SEL_RF;
    stall_o   = 1'b0;
    if (w_hit) begin
      if ((FWD_EN != 0) && w_vld) fwd_sel_o = w_sel;
      else                        stall_o   = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode hazard controller: branch flush window, operand forwarding/stall
// decisions and saturating stall/flush performance counters.
module hazard_ctrl
  import ecap5_dproc_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int NB_STAGES    = NB_STAGES_DEF,
  parameter int FWD_EN       = FWD_EN_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   branch_i,
  input  logic                   dec_valid_i,
  input  logic [4:0]             dec_raddr1_i,
  input  logic [4:0]             dec_raddr2_i,
  input  logic [NB_STAGES-1:0]   stg_reg_write_i,
  input  logic [5*NB_STAGES-1:0] stg_reg_addr_i,
  input  logic [NB_STAGES-1:0]   stg_result_valid_i,
  input  logic                   cnt_clear_i,
  output logic                   ex_discard_o,
  output logic                   dec_stall_request_o,
  output logic [2:0]             dec_fwd_sel1_o,
  output logic [2:0]             dec_fwd_sel2_o,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            flush_cnt_o
);

  localparam int               FC_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES);

  logic [FC_W-1:0] r_flush_ctr;
  logic [31:0]     r_stall_cnt;
  logic [31:0]     r_flush_cnt;
  logic [2:0]      w_sel1;
  logic [2:0]      w_sel2;
  logic            w_stall1;
  logic            w_stall2;
  logic            w_stall;

  hazard_match #(.NB_STAGES(NB_STAGES), .FWD_EN(FWD_EN)) u_match1 (
    .raddr_i            (dec_raddr1_i),
    .stg_reg_write_i    (stg_reg_write_i),
    .stg_reg_addr_i     (stg_reg_addr_i),
    .stg_result_valid_i (stg_result_valid_i),
    .fwd_sel_o          (w_sel1),
    .stall_o            (w_stall1)
  );

  hazard_match #(.NB_STAGES(NB_STAGES), .FWD_EN(FWD_EN)) u_match2 (
    .raddr_i            (dec_raddr2_i),
    .stg_reg_write_i    (stg_reg_write_i),
    .stg_reg_addr_i     (stg_reg_addr_i),
    .stg_result_valid_i (stg_result_valid_i),
    .fwd_sel_o          (w_sel2),
    .stall_o            (w_stall2)
  );

  // A new branch always restarts the window rather than extending it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flush_ctr <= '0;
    end else if (branch_i) begin
      r_flush_ctr <= FC_LOAD;
    end else if (r_flush_ctr != '0) begin
      r_flush_ctr <= r_flush_ctr - FC_W'(1);
    end
  end

  assign ex_discard_o = (r_flush_ctr != '0);

  // An instruction being discarded cannot hold decode.
  assign w_stall             = dec_valid_i && !ex_discard_o && (w_stall1 || w_stall2);
  assign dec_stall_request_o = w_stall;
  assign dec_fwd_sel1_o      = dec_valid_i ? w_sel1 : FWD_SEL_RF;
  assign dec_fwd_sel2_o      = dec_valid_i ? w_sel2 : FWD_SEL_RF;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clear_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall)  r_stall_cnt <= sat_inc32(r_stall_cnt);
      if (branch_i) r_flush_cnt <= sat_inc32(r_flush_cnt);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule
